// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit general-purpose register file for the ID stage.
// Two combinational read ports (rs/rt operands) and one write port driven by WB.
// Register 0 is hardwired to zero and has no storage.
// There is no write-through: a read of the register being written returns the
// pre-edge value. WB->ID forwarding is the ID stage's job.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage exists only for registers 1..DEPTH-1. Every entry has to clear on
    // an asynchronous reset, so this cannot map onto block RAM and is built from
    // flops instead.
    logic [DATA_W-1:0] regs_reg [1:DEPTH-1];

    // One-hot write select. Address 0 has no select line, which discards any
    // write to it.
    logic [DEPTH-1:1] wr_sel;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
            assign wr_sel[gi] = we && (wa == ADDR_W'(gi));

            // Per-register storage: async clear, then load on a selected write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    regs_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    // Read port 1: zero-latency mux. Address 0 reads as constant zero.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = regs_reg[ra1];
        end
    end

    // Read port 2: identical to port 1, driven by ra2.
    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = regs_reg[ra2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios, then randomized traffic checked against a
// plain array model of the register file.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the architectural register contents.
    logic [31:0] model [32];

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa    (wa),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Advance one clock edge. The model commits the write that the DUT sees at
    // that edge. Register 0 never changes and reset blocks the write.
    task automatic tick();
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) model[wa] = wd;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        we = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
        model_clear();

        // 1. Reset, then sweep both ports over every address.
        rst_n = 1'b0;
        #17;
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            check($sformatf("reset_rd1[%0d]", a), rd1, model[a]);
            check($sformatf("reset_rd2[%0d]", 31 - a), rd2, model[31 - a]);
        end
        $display("step reset sweep done");

        // 2. Basic write then read on both ports.
        write_reg(5'd5, 32'hDEADBEEF);
        ra1 = 5'd5; ra2 = 5'd5;
        #1;
        check("basic_rd1", rd1, 32'hDEADBEEF);
        check("basic_rd2", rd2, 32'hDEADBEEF);
        $display("step write r5=deadbeef");

        // 3. Writes to register 0 are discarded.
        write_reg(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0;
        #1;
        check("r0_rd1", rd1, 32'h0);
        $display("step write r0=ffffffff (discarded)");

        // 4. No write-through: old value before the edge, new one after.
        write_reg(5'd7, 32'h11111111);
        ra2 = 5'd7;
        we = 1'b1; wa = 5'd7; wd = 32'h22222222;
        #1;
        check("nobypass_pre", rd2, 32'h11111111);
        tick();
        we = 1'b0;
        check("nobypass_post", rd2, 32'h22222222);
        $display("step write r7=22222222 no bypass");

        // 5. Two ports on different registers while writes are disabled.
        write_reg(5'd1, 32'hA);
        write_reg(5'd2, 32'hB);
        ra1 = 5'd1; ra2 = 5'd2;
        we = 1'b0; wa = 5'd1; wd = 32'hC;
        tick();
        check("dual_rd1", rd1, 32'hA);
        check("dual_rd2", rd2, 32'hB);
        $display("step we=0 write suppressed");

        // 6. Fill registers 1..31, then apply async reset between edges.
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        ra1 = 5'd31; ra2 = 5'd16;
        #1;
        check("fill_r31", rd1, model[31]);
        check("fill_r16", rd2, model[16]);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_r31", rd1, 32'h0);
        check("async_rst_r16", rd2, 32'h0);
        // A write during reset loses to reset.
        we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra1 = 5'd3;
        tick();
        check("rst_priority", rd1, 32'h0);
        we = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            check($sformatf("post_rst[%0d]", a), rd1, 32'h0);
        end
        $display("step async reset mid-run");

        // Random traffic. Reads are checked before each edge, so they see
        // pre-edge contents. An occasional async reset is applied mid-cycle.
        for (int t = 0; t < 200; t++) begin
            we  = 1'($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 4) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 4) == 0) ? ra1 : 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rand%0d_rd1", t), rd1, model[ra1]);
            check($sformatf("rand%0d_rd2", t), rd2, model[ra2]);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                check($sformatf("rand%0d_rst", t), rd1, 32'h0);
                rst_n = 1'b1;
                $display("txn %0d async reset", t);
            end else begin
                $display("txn %0d we=%0d wa=%0d wd=%08h ra1=%0d ra2=%0d", t, we, wa, wd, ra1, ra2);
            end
            tick();
        end
        we = 1'b0;

        // Read back the final contents on both ports.
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(a);
            #1;
            check($sformatf("final_rd1[%0d]", a), rd1, model[a]);
            check($sformatf("final_rd2[%0d]", a), rd2, model[a]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
